// File: rtl/ppu_timing.sv
`default_nettype none
// ============================================================================
// Module      : ppu_timing
// Description : Scanline/frame timing generator for a tile-based PPU. Keeps
//               dot and line counters and decodes the PPU mode, the memory
//               access flags, LY=LYC compare, the edge-detected STAT
//               interrupt and the line/frame/VBLANK event pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module ppu_timing #(
    parameter int DOTS_PER_LINE = 456,
    parameter int OAM_DOTS      = 80,
    parameter int XFER_DOTS     = 172,
    parameter int VISIBLE_LINES = 144,
    parameter int TOTAL_LINES   = 154,
    parameter int DOT_STEP      = 2
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic                             tick,
    input  logic                             lcd_enable,
    input  logic [7:0]                       lyc,
    input  logic [3:0]                       stat_ie,
    output logic [$clog2(DOTS_PER_LINE)-1:0] dot,
    output logic [7:0]                       ly,
    output logic [1:0]                       ppu_mode,
    output logic                             vblank,
    output logic                             oam_access,
    output logic                             vram_access,
    output logic                             lyc_match,
    output logic                             stat_irq,
    output logic                             vblank_irq,
    output logic                             line_start,
    output logic                             frame_start
);

    localparam int c_dot_w = $clog2(DOTS_PER_LINE);

    // Dot arithmetic is carried one bit wider so the end-of-line sum never
    // overflows the counter width.
    localparam logic [c_dot_w:0] c_dots_per_line = (c_dot_w + 1)'(DOTS_PER_LINE);
    localparam logic [c_dot_w:0] c_dot_step      = (c_dot_w + 1)'(DOT_STEP);
    localparam logic [c_dot_w:0] c_oam_end       = (c_dot_w + 1)'(OAM_DOTS);
    localparam logic [c_dot_w:0] c_xfer_end      = (c_dot_w + 1)'(OAM_DOTS + XFER_DOTS);
    localparam logic [8:0]       c_visible_lines = 9'(VISIBLE_LINES);
    localparam logic [7:0]       c_last_line     = 8'(TOTAL_LINES - 1);

    localparam logic [1:0] c_mode_hblank = 2'd0;
    localparam logic [1:0] c_mode_vblank = 2'd1;
    localparam logic [1:0] c_mode_oam    = 2'd2;
    localparam logic [1:0] c_mode_xfer   = 2'd3;

    logic [c_dot_w-1:0] r_dot;
    logic [7:0]         r_ly;
    logic               r_stat_prev;
    logic               r_stat_irq;
    logic               r_line_evt;
    logic               r_line_start;
    logic               r_frame_evt;
    logic               r_frame_start;
    logic               r_vbl_evt;
    logic               r_vblank_irq;

    logic [c_dot_w:0]   w_dot_sum;
    logic               w_line_wrap;
    logic               w_frame_wrap;
    logic               w_vbl_entry;
    logic [7:0]         w_ly_next;
    logic [1:0]         w_mode;
    logic               w_stat_line;

    // Next-count arithmetic and the wrap events it produces on this tick.
    always_comb begin
        w_dot_sum    = {1'b0, r_dot} + c_dot_step;
        w_line_wrap  = tick && (w_dot_sum == c_dots_per_line);
        w_frame_wrap = w_line_wrap && (r_ly == c_last_line);
        w_ly_next    = w_frame_wrap ? 8'd0 : r_ly + 8'd1;
        w_vbl_entry  = w_line_wrap && ({1'b0, w_ly_next} == c_visible_lines);
    end

    // Dot/line counters; LCD off parks them at the top of the frame.
    always_ff @(posedge clock) begin
        if (reset || !lcd_enable) begin
            r_dot <= '0;
            r_ly  <= 8'd0;
        end else if (tick) begin
            if (w_line_wrap) begin
                r_dot <= '0;
                r_ly  <= w_ly_next;
            end else begin
                r_dot <= w_dot_sum[c_dot_w-1:0];
            end
        end
    end

    // Mode decode in priority order; LCD off forces HBLANK.
    always_comb begin
        w_mode = c_mode_hblank;
        if ({1'b0, r_ly} >= c_visible_lines) begin
            w_mode = c_mode_vblank;
        end else if ({1'b0, r_dot} < c_oam_end) begin
            w_mode = c_mode_oam;
        end else if ({1'b0, r_dot} < c_xfer_end) begin
            w_mode = c_mode_xfer;
        end
        if (!lcd_enable) begin
            w_mode = c_mode_hblank;
        end
    end

    // Combined STAT line; reacts to stat_ie/lyc without waiting for a clock.
    always_comb begin
        w_stat_line = lcd_enable && (
                      (stat_ie[0] && (w_mode == c_mode_hblank)) ||
                      (stat_ie[1] && (w_mode == c_mode_vblank)) ||
                      (stat_ie[2] && (w_mode == c_mode_oam))    ||
                      (stat_ie[3] && lyc_match));
    end

    // Event pulses: a wrap is latched first, then reported one clock later.
    // The STAT edge detector compares against the previous cycle's line so a
    // line held high across a mode change never re-fires.
    always_ff @(posedge clock) begin
        if (reset || !lcd_enable) begin
            r_stat_prev   <= 1'b0;
            r_stat_irq    <= 1'b0;
            r_line_evt    <= 1'b0;
            r_line_start  <= 1'b0;
            r_frame_evt   <= 1'b0;
            r_frame_start <= 1'b0;
            r_vbl_evt     <= 1'b0;
            r_vblank_irq  <= 1'b0;
        end else begin
            r_stat_prev   <= w_stat_line;
            r_stat_irq    <= w_stat_line && !r_stat_prev;
            r_line_evt    <= w_line_wrap;
            r_line_start  <= r_line_evt;
            r_frame_evt   <= w_frame_wrap;
            r_frame_start <= r_frame_evt;
            r_vbl_evt     <= w_vbl_entry;
            r_vblank_irq  <= r_vbl_evt;
        end
    end

    assign dot         = lcd_enable ? r_dot : '0;
    assign ly          = lcd_enable ? r_ly : 8'd0;
    assign ppu_mode    = w_mode;
    assign vblank      = (w_mode == c_mode_vblank);
    assign oam_access  = (w_mode == c_mode_oam) || (w_mode == c_mode_xfer);
    assign vram_access = (w_mode == c_mode_xfer);
    assign lyc_match   = lcd_enable && (r_ly == lyc);
    assign stat_irq    = lcd_enable && r_stat_irq;
    assign vblank_irq  = lcd_enable && r_vblank_irq;
    assign line_start  = lcd_enable && r_line_start;
    assign frame_start = lcd_enable && r_frame_start;

endmodule
`default_nettype wire

// File: tb/tb_ppu_timing.sv
`default_nettype none
// ============================================================================
// Module      : tb_ppu_timing
// Description : Self-checking bench for ppu_timing. A position-based model
//               (ticks since restart -> dot/line by division) predicts every
//               output each cycle; directed checkpoints cover line, VBLANK,
//               frame, LYC, STAT blocking and LCD off/on timing.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ppu_timing;

    localparam int DPL  = 456;
    localparam int OAM  = 80;
    localparam int XFER = 172;
    localparam int VIS  = 144;
    localparam int TL   = 154;
    localparam int STEP = 2;

    logic       clock = 1'b0;
    logic       reset;
    logic       tick;
    logic       lcd_enable;
    logic [7:0] lyc;
    logic [3:0] stat_ie;
    logic [8:0] dot;
    logic [7:0] ly;
    logic [1:0] ppu_mode;
    logic       vblank, oam_access, vram_access, lyc_match;
    logic       stat_irq, vblank_irq, line_start, frame_start;

    int checks = 0;
    int errors = 0;
    int clk_n  = 0;
    int irq_cnt = 0;
    int snap;

    // Reference model state
    bit m_valid = 0;
    int m_ticks = 0;
    bit m_sprev, m_irq;
    bit m_line_evt, m_line_start, m_frame_evt, m_frame_start, m_vbl_evt, m_vbl_irq;

    ppu_timing #(
        .DOTS_PER_LINE(DPL), .OAM_DOTS(OAM), .XFER_DOTS(XFER),
        .VISIBLE_LINES(VIS), .TOTAL_LINES(TL), .DOT_STEP(STEP)
    ) dut (
        .clock(clock), .reset(reset), .tick(tick), .lcd_enable(lcd_enable),
        .lyc(lyc), .stat_ie(stat_ie), .dot(dot), .ly(ly), .ppu_mode(ppu_mode),
        .vblank(vblank), .oam_access(oam_access), .vram_access(vram_access),
        .lyc_match(lyc_match), .stat_irq(stat_irq), .vblank_irq(vblank_irq),
        .line_start(line_start), .frame_start(frame_start)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int e_dot();
        return lcd_enable ? (m_ticks * STEP) % DPL : 0;
    endfunction

    function automatic int e_ly();
        return lcd_enable ? ((m_ticks * STEP) / DPL) % TL : 0;
    endfunction

    function automatic int e_mode();
        if (!lcd_enable) return 0;
        if (e_ly() >= VIS) return 1;
        if (e_dot() < OAM) return 2;
        if (e_dot() < OAM + XFER) return 3;
        return 0;
    endfunction

    function automatic bit e_lyc();
        return lcd_enable && (e_ly() == int'(lyc));
    endfunction

    function automatic bit e_stat_line();
        int m;
        m = e_mode();
        return lcd_enable && ((stat_ie[0] && m == 0) || (stat_ie[1] && m == 1) ||
                              (stat_ie[2] && m == 2) || (stat_ie[3] && e_lyc()));
    endfunction

    task automatic check_model();
        int m;
        if (!m_valid) return;
        m = e_mode();
        chk("dot", 32'(dot), 32'(e_dot()));
        chk("ly", 32'(ly), 32'(e_ly()));
        chk("ppu_mode", 32'(ppu_mode), 32'(m));
        chk("vblank", 32'(vblank), 32'(m == 1));
        chk("oam_access", 32'(oam_access), 32'(m == 2 || m == 3));
        chk("vram_access", 32'(vram_access), 32'(m == 3));
        chk("lyc_match", 32'(lyc_match), 32'(e_lyc()));
        chk("stat_irq", 32'(stat_irq), 32'(lcd_enable && m_irq));
        chk("vblank_irq", 32'(vblank_irq), 32'(lcd_enable && m_vbl_irq));
        chk("line_start", 32'(line_start), 32'(lcd_enable && m_line_start));
        chk("frame_start", 32'(frame_start), 32'(lcd_enable && m_frame_start));
    endtask

    task automatic model_update();
        bit s;
        int pos;
        m_valid = 1;
        if (reset || !lcd_enable) begin
            m_ticks = 0;
            {m_sprev, m_irq} = 2'b00;
            {m_line_evt, m_line_start, m_frame_evt, m_frame_start, m_vbl_evt, m_vbl_irq} = 6'b0;
        end else begin
            s = e_stat_line();
            m_irq = s && !m_sprev;
            m_sprev = s;
            m_line_start  = m_line_evt;
            m_frame_start = m_frame_evt;
            m_vbl_irq     = m_vbl_evt;
            {m_line_evt, m_frame_evt, m_vbl_evt} = 3'b000;
            if (tick) begin
                m_ticks++;
                pos = m_ticks * STEP;
                if (pos % DPL == 0) begin
                    m_line_evt  = 1;
                    m_frame_evt = ((pos / DPL) % TL) == 0;
                    m_vbl_evt   = ((pos / DPL) % TL) == VIS;
                end
            end
        end
    endtask

    // One full clock: check at negedge, advance model at posedge.
    task automatic cycle();
        @(negedge clock);
        check_model();
        if (stat_irq === 1'b1) irq_cnt++;
        @(posedge clock);
        model_update();
        #1;
        clk_n++;
    endtask

    task automatic run_to(input int n);
        while (clk_n < n) cycle();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cycle();
        cycle();
        reset = 1'b0;
        clk_n = 0;
    endtask

    initial begin
        reset = 1'b1; tick = 1'b1; lcd_enable = 1'b1; lyc = 8'd200; stat_ie = 4'b0000;

        // Reset state and line timing
        do_reset();
        chk("rst_dot", 32'(dot), 0);
        chk("rst_ly", 32'(ly), 0);
        chk("rst_mode", 32'(ppu_mode), 2);
        chk("rst_pulse", 32'({stat_irq, vblank_irq, line_start, frame_start}), 0);
        run_to(39);    chk("c39_mode", 32'(ppu_mode), 2);
        run_to(40);    chk("c40_mode", 32'(ppu_mode), 3);
                       chk("c40_dot", 32'(dot), 80);
        run_to(125);   chk("c125_mode", 32'(ppu_mode), 3);
        run_to(126);   chk("c126_mode", 32'(ppu_mode), 0);
        run_to(228);   chk("c228_ly", 32'(ly), 1);
                       chk("c228_dot", 32'(dot), 0);
                       chk("c228_ls", 32'(line_start), 0);
        run_to(229);   chk("c229_ls", 32'(line_start), 1);
        run_to(230);   chk("c230_ls", 32'(line_start), 0);

        // VBLANK entry and frame wrap
        run_to(32832); chk("vbl_ly", 32'(ly), 144);
                       chk("vbl_mode", 32'(ppu_mode), 1);
                       chk("vbl_irq0", 32'(vblank_irq), 0);
        run_to(32833); chk("vbl_irq1", 32'(vblank_irq), 1);
        run_to(32834); chk("vbl_irq2", 32'(vblank_irq), 0);
        run_to(35112); chk("fr_ly", 32'(ly), 0);
                       chk("fr_mode", 32'(ppu_mode), 2);
        run_to(35113); chk("fr_start", 32'(frame_start), 1);
        run_to(35114); chk("fr_start_end", 32'(frame_start), 0);

        // LYC interrupt
        lyc = 8'd5; stat_ie = 4'b1000;
        do_reset();
        run_to(1140);  chk("lyc_ly", 32'(ly), 5);
                       chk("lyc_match", 32'(lyc_match), 1);
                       chk("lyc_irq0", 32'(stat_irq), 0);
        run_to(1141);  chk("lyc_irq1", 32'(stat_irq), 1);
        run_to(1142);  snap = irq_cnt;
        run_to(1368);  chk("lyc_ly6_match", 32'(lyc_match), 0);
        run_to(1596);  chk("lyc_no_extra", 32'(irq_cnt - snap), 0);

        // STAT blocking with HBLANK + OAM sources
        lyc = 8'd0; stat_ie = 4'b0101;
        do_reset();
        run_to(2);     snap = irq_cnt;
        run_to(41);    chk("blk_oam_exit", 32'(stat_irq), 0);
        run_to(127);   chk("blk_hbl0", 32'(stat_irq), 1);
        run_to(229);   chk("blk_boundary", 32'(stat_irq), 0);
        run_to(355);   chk("blk_hbl1", 32'(stat_irq), 1);
        run_to(357);   chk("blk_count", 32'(irq_cnt - snap), 2);

        // LCD off / on
        do_reset();
        run_to(16110); chk("off_pre_ly", 32'(ly), 70);
                       chk("off_pre_dot", 32'(dot), 300);
        lcd_enable = 1'b0;
        cycle();
        chk("off_dot", 32'(dot), 0);
        chk("off_ly", 32'(ly), 0);
        chk("off_mode", 32'(ppu_mode), 0);
        chk("off_pulse", 32'({stat_irq, vblank_irq, line_start, frame_start, lyc_match}), 0);
        tick = 1'b0;
        repeat (3) cycle();
        lcd_enable = 1'b1;
        repeat (3) cycle();
        chk("on_hold_mode", 32'(ppu_mode), 2);
        chk("on_hold_dot", 32'(dot), 0);
        tick = 1'b1;
        repeat (3) cycle();
        chk("on_run_dot", 32'(dot), 6);
        repeat (300) cycle();
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        chk("midreset_dot", 32'(dot), 0);
        chk("midreset_ly", 32'(ly), 0);
        chk("midreset_pulse", 32'({stat_irq, vblank_irq, line_start, frame_start}), 0);

        // Randomized traffic against the model
        for (int i = 0; i < 4000; i++) begin
            tick       = ($urandom_range(0, 3) != 0);
            lcd_enable = ($urandom_range(0, 199) != 0);
            reset      = ($urandom_range(0, 499) == 0);
            if ($urandom_range(0, 49) == 0) lyc = 8'($urandom_range(0, 3));
            if ($urandom_range(0, 29) == 0) stat_ie = 4'($urandom_range(0, 15));
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
